// File: rtl/game_sequencer_if.sv
// Draw-pass handshake bundle between the game sequencer and the map/sprite drawers.
// The sequencer is the master: it raises the enables and owns the VGA port select.
interface game_sequencer_if;
  logic draw_map;
  logic map_draw_done;
  logic draw_link;
  logic link_draw_done;
  logic vga_sel;

  modport master (
    output draw_map,
    output draw_link,
    output vga_sel,
    input  map_draw_done,
    input  link_draw_done
  );

  modport slave (
    input  draw_map,
    input  draw_link,
    input  vga_sel,
    output map_draw_done,
    output link_draw_done
  );
endinterface

// File: rtl/game_sequencer.sv
// Frame-paced game-loop controller: input latch, settle, move, map draw, sprite draw.
// Optional draw-pass watchdog is enabled by defining DRAW_WATCHDOG_EN.
module game_sequencer #(
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  game_sequencer_if.master         draw,
  output logic                     init,
  output logic                     idle,
  output logic                     reg_action,
  output logic                     apply_action,
  output logic [15:0]              frame_count,
  output logic [7:0]               overrun,
  output logic                     timeout_err
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_INIT,
    S_WAIT,
    S_REG,
    S_SETTLE,
    S_APPLY,
    S_MAP,
    S_LINK
  } state_t;

  localparam logic [19:0] T_LAST = 20'(FRAME_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [19:0] timer;
  logic        pending;
  logic        tick;
  logic        ov_bump;
  logic        wd_hit;
  logic        map_fin;
  logic        link_fin;

  assign tick    = (state != S_BOOT) && (timer == T_LAST);
  assign ov_bump = tick && pending;

`ifdef DRAW_WATCHDOG_EN
  localparam logic [16:0] WD_LAST = 17'(TIMEOUT_CYCLES - 1);

  logic [16:0] wd_cnt;
  logic        in_draw;

  assign in_draw = (state == S_MAP) || (state == S_LINK);
  assign wd_hit  = in_draw && (wd_cnt == WD_LAST);

  // Counter restarts whenever a draw pass is entered, including MAP->LINK.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state_n != state) &&
          ((state_n == S_MAP) || (state_n == S_LINK)))
        wd_cnt <= '0;
      else if (in_draw)
        wd_cnt <= wd_cnt + 17'd1;
      if (wd_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign map_fin  = draw.map_draw_done | wd_hit;
  assign link_fin = draw.link_draw_done | wd_hit;

  always_comb begin
    state_n = state;
    unique case (state)
      S_BOOT:   if (start) state_n = S_INIT;
      S_INIT:   state_n = S_MAP;
      S_WAIT:   if (tick || pending) state_n = S_REG;
      S_REG:    state_n = S_SETTLE;
      S_SETTLE: state_n = S_APPLY;
      S_APPLY:  state_n = S_MAP;
      S_MAP:    if (map_fin) state_n = S_LINK;
      S_LINK:   if (link_fin) state_n = S_WAIT;
      default:  state_n = S_BOOT;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_BOOT;
      timer          <= '0;
      pending        <= 1'b0;
      frame_count    <= '0;
      overrun        <= '0;
      init           <= 1'b0;
      idle           <= 1'b0;
      reg_action     <= 1'b0;
      apply_action   <= 1'b0;
      draw.draw_map  <= 1'b0;
      draw.draw_link <= 1'b0;
      draw.vga_sel   <= 1'b0;
    end else begin
      state <= state_n;

      if (state == S_BOOT || tick)
        timer <= '0;
      else
        timer <= timer + 20'd1;

      if (state == S_WAIT)
        pending <= 1'b0;
      else if (tick)
        pending <= 1'b1;

      if (ov_bump && overrun != 8'hFF)
        overrun <= overrun + 8'd1;

      if (state == S_LINK && state_n == S_WAIT)
        frame_count <= frame_count + 16'd1;

      init           <= state_n == S_INIT;
      idle           <= state_n == S_WAIT;
      reg_action     <= state_n == S_REG;
      apply_action   <= state_n == S_APPLY;
      draw.draw_map  <= state_n == S_MAP;
      draw.draw_link <= state_n == S_LINK;
      draw.vga_sel   <= state_n == S_LINK;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer against a phase/age reference model.
// Define DRAW_WATCHDOG_EN for both bench and RTL to exercise the watchdog.
module tb_game_sequencer;

  localparam int F     = 16;
  localparam int TO    = 32;
  localparam int NEVER = 1 << 30;

  localparam int P_BOOT   = 0;
  localparam int P_INIT   = 1;
  localparam int P_WAIT   = 2;
  localparam int P_REG    = 3;
  localparam int P_SETTLE = 4;
  localparam int P_APPLY  = 5;
  localparam int P_MAP    = 6;
  localparam int P_LINK   = 7;

`ifdef DRAW_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        init;
  logic        idle;
  logic        reg_action;
  logic        apply_action;
  logic [15:0] frame_count;
  logic [7:0]  overrun;
  logic        timeout_err;

  game_sequencer_if draw ();

  game_sequencer #(
    .FRAME_CYCLES  (F),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .draw        (draw),
    .init        (init),
    .idle        (idle),
    .reg_action  (reg_action),
    .apply_action(apply_action),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  // Model: current phase, cycles spent in it, cycles since leaving BOOT.
  int ph;
  int age;
  int run;
  int m_fc;
  int m_ov;
  bit m_pend;
  bit m_terr;

  int md;
  int ld;
  bit noise;

  int n_chk;
  int n_err;

  // One-hot {init,idle,reg,apply,map,link} expected per phase.
  logic [5:0] strobe_tbl [8];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st,
                            input bit mdn, input bit ldn);
    bit tick;
    bit wdt;
    int nph;
    if (rst) begin
      ph = P_BOOT; age = 0; run = 0;
      m_pend = 0; m_fc = 0; m_ov = 0; m_terr = 0;
      return;
    end
    tick = (ph != P_BOOT) && ((run % F) == F - 1);
    run  = (ph == P_BOOT) ? 0 : run + 1;
    wdt  = WD && (ph == P_MAP || ph == P_LINK) && age == TO - 1;
    if (wdt) m_terr = 1;
    nph = ph;
    case (ph)
      P_BOOT:   if (st) nph = P_INIT;
      P_INIT:   nph = P_MAP;
      P_WAIT:   if (tick || m_pend) nph = P_REG;
      P_REG:    nph = P_SETTLE;
      P_SETTLE: nph = P_APPLY;
      P_APPLY:  nph = P_MAP;
      P_MAP:    if (mdn || wdt) nph = P_LINK;
      P_LINK:   if (ldn || wdt) begin
                  nph = P_WAIT;
                  m_fc = (m_fc + 1) % 65536;
                end
      default:  nph = P_BOOT;
    endcase
    if (tick && m_pend && m_ov < 255) m_ov++;
    if (ph == P_WAIT) m_pend = 0;
    else if (tick) m_pend = 1;
    age = (nph == ph) ? age + 1 : 0;
    ph  = nph;
  endtask

  task automatic cycle();
    bit mdn;
    bit ldn;
    @(negedge clock);
    mdn = (ph == P_MAP)  ? (age >= md) : (noise && $urandom_range(0, 3) == 0);
    ldn = (ph == P_LINK) ? (age >= ld) : (noise && $urandom_range(0, 3) == 0);
    draw.map_draw_done  = mdn;
    draw.link_draw_done = ldn;
    model_step(reset, start, mdn, ldn);
    @(posedge clock);
    #1;
    check("strobes",
          32'({init, idle, reg_action, apply_action,
               draw.draw_map, draw.draw_link}),
          32'(strobe_tbl[ph]));
    check("vga_sel", 32'(draw.vga_sel), 32'(ph == P_LINK));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("overrun", 32'(overrun), 32'(m_ov));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  initial begin
    strobe_tbl[P_BOOT]   = 6'b000000;
    strobe_tbl[P_INIT]   = 6'b100000;
    strobe_tbl[P_WAIT]   = 6'b010000;
    strobe_tbl[P_REG]    = 6'b001000;
    strobe_tbl[P_SETTLE] = 6'b000000;
    strobe_tbl[P_APPLY]  = 6'b000100;
    strobe_tbl[P_MAP]    = 6'b000010;
    strobe_tbl[P_LINK]   = 6'b000001;

    n_chk = 0;
    n_err = 0;
    md = 3;
    ld = 3;
    noise = 0;
    ph = P_BOOT; age = 0; run = 0;
    m_pend = 0; m_fc = 0; m_ov = 0; m_terr = 0;
    draw.map_draw_done  = 1'b0;
    draw.link_draw_done = 1'b0;

    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (2) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (100) cycle();

    noise = 1;
    for (int i = 0; i < 40; i++) begin
      md = $urandom_range(0, 12);
      ld = $urandom_range(0, 12);
      repeat (40) cycle();
    end

    noise = 0;
    md = 4200;
    ld = 2;
    repeat (4600) cycle();
    md = 3;
    ld = 3;
    repeat (100) cycle();

    for (int i = 0; i < 100 && !draw.draw_link; i++) cycle();
    check("reach_link", 32'(draw.draw_link), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (20) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (60) cycle();

    md = NEVER;
    repeat (200) cycle();
    md = 3;
    repeat (100) cycle();

    noise = 1;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 2) == 0);
      md = $urandom_range(0, 6);
      ld = $urandom_range(0, 6);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-loop controller for the player-character datapath. Paces the design to a fixed frame rate. Each frame it steps the character logic through input latch, collision settle and move, then the two draw passes: background map first, character sprite second. It also owns the select for the shared VGA write port. It sits between the board clock/start button and the character, map-drawer and collision blocks.

## Interface
Parameters:
- FRAME_CYCLES, 833333: clock cycles per frame period (50 MHz / 60 Hz); legal range 16 to 2^20.
- TIMEOUT_CYCLES, 131072: draw-pass watchdog limit, used only with the configuration macro.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high; clock clock.
- start  input  1  level; leaves BOOT when high.
- map_draw_done  input  1  map drawer finished (level, held until draw_map drops).
- link_draw_done  input  1  character sprite draw finished (level, held until draw_link drops).
- init  output  1  character/map initialise strobe.
- idle  output  1  waiting for frame tick.
- reg_action  output  1  latch user command into character block.
- apply_action  output  1  apply move using settled collision result.
- draw_map  output  1  map drawer enable.
- draw_link  output  1  character draw enable.
- vga_sel  output  1  0 = map drawer owns VGA port, 1 = character owns it.
- frame_count  output  16  completed frames, wraps.
- overrun  output  8  frame ticks missed while busy, saturates at 255.
- timeout_err  output  1  sticky watchdog flag (0 when macro absent).

## Operation
- States: BOOT, INIT, WAIT, REG, SETTLE, APPLY, MAP, LINK.
- Exactly one of init/idle/reg_action/apply_action/draw_map/draw_link is high in INIT/WAIT/REG/APPLY/MAP/LINK; all six are low in BOOT and SETTLE. All outputs are Moore, registered from the state.
- BOOT -> INIT when start=1.
- INIT lasts 1 cycle, then -> MAP. The first frame draws before any input is read.
- WAIT -> REG on tick or pending tick; pending is consumed.
- REG, SETTLE and APPLY each last 1 cycle, then advance in that order to MAP. SETTLE gives the collision detector one cycle on the new direction.
- MAP -> LINK when map_draw_done=1.
- LINK -> WAIT when link_draw_done=1; frame_count increments on that transition.
- vga_sel = 1 only in LINK, 0 otherwise.
- Frame timer: a 20-bit counter runs in every state except BOOT. It counts 0..FRAME_CYCLES-1, then wraps, and the wrap cycle is the tick.
- A tick outside WAIT sets pending. A tick while pending is already set increments overrun (saturating). At most one pending tick is held.
- A tick and a pending tick together in WAIT count as one consumed tick plus one overrun increment.
- Done inputs are ignored outside their own state.

## Timing
- Reset values: state BOOT, all strobes 0, vga_sel 0, timer 0, pending 0, frame_count 0, overrun 0, timeout_err 0.
- Reset mid-frame returns to BOOT on the next edge. Draw enables drop immediately, so no partial-frame completion occurs.
- start=1 at edge N: INIT high in cycle N+1, draw_map high in N+2.
- Tick at cycle T while in WAIT: reg_action high at T+1, apply_action at T+3, draw_map at T+4.
- Done seen high at edge E: the enable is low from E+1. The next state's enable is high from E+1 (no gap MAP->LINK).
- Timer keeps counting through all states. The tick period is exactly FRAME_CYCLES regardless of draw length.

## Configuration
- DRAW_WATCHDOG_EN defined:
  - A 17-bit counter clears on entry to MAP and to LINK.
  - If it reaches TIMEOUT_CYCLES-1 in MAP or LINK, the state advances as if done had arrived and timeout_err sets sticky until reset.
  - In MAP/LINK the counter increments every cycle.
- Undefined: no counter; MAP/LINK wait indefinitely; timeout_err tied 0.

## Test plan
- Reset, start=1 at cycle 5, FRAME_CYCLES=16, dones stubbed to assert 3 cycles after enable. Expected: init at 6, draw_map 7-10, draw_link 11-14, idle from 15, frame_count=1.
- Steady state, same stub: the reg_action pulse repeats every 16 cycles and each pulse is followed by apply_action 2 cycles later; frame_count increments every frame; overrun stays 0.
- Map stub delay of 40 cycles with FRAME_CYCLES=16. Expected: overrun increments per missed tick; a single pending tick gives reg_action on the first cycle after idle is entered; overrun saturates at 255 after a long stall.
- Assert reset during LINK. Expected: next cycle all strobes 0, vga_sel=0, frame_count=0; no activity until start.
- DRAW_WATCHDOG_EN with TIMEOUT_CYCLES=32 and map_draw_done held 0. Expected: draw_map lasts 32 cycles, then draw_link rises; timeout_err=1 and stays 1.
- Assert link_draw_done during MAP. Expected: ignored; vga_sel stays 0 until map_draw_done is seen.
